// File: rtl/dcf_frame_sequencer.sv
// DCF77 frame sequencer: classifies pulse widths on the 1 kHz tick, locks on the minute gap,
// assembles the 59-bit frame and commits it only when count, markers and parity all check.
module dcf_frame_sequencer #(
    parameter int unsigned MIN_0   = 40,
    parameter int unsigned MAX_0   = 149,
    parameter int unsigned MAX_1   = 260,
    parameter int unsigned GAP_MIN = 1500,
    parameter int unsigned CNT_W   = 12
) (
    input  logic        qzt_clk_i,
    input  logic        reset_i,
    input  logic        tick_1khz_i,
    input  logic        sgn_in_i,
    input  logic        enable_sincro_i,
    output logic [58:0] frame_out_o,
    output logic        frame_valid_o,
    output logic        sincro_o,
    output logic [5:0]  bit_index_o,
    output logic [2:0]  last_err_o
);

    typedef enum logic [2:0] {StIdle, StHunt, StArmed, StReceive, StCheck} state_e;

    localparam logic [2:0] ErrNone   = 3'd0;
    localparam logic [2:0] ErrWidth  = 3'd1;
    localparam logic [2:0] ErrCount  = 3'd2;
    localparam logic [2:0] ErrParity = 3'd3;
    localparam logic [2:0] ErrMarker = 3'd4;

    localparam logic [CNT_W-1:0] CntMax  = '1;
    localparam logic [CNT_W-1:0] Min0    = CNT_W'(MIN_0);
    localparam logic [CNT_W-1:0] Max0    = CNT_W'(MAX_0);
    localparam logic [CNT_W-1:0] Max1    = CNT_W'(MAX_1);
    localparam logic [CNT_W-1:0] GapLast = CNT_W'(GAP_MIN - 1);
    localparam logic [5:0]       LastBit = 6'd59;

    logic             sync1_q, sync2_q, samp_q;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d, lo_cnt_q, lo_cnt_d;
    state_e           state_q, state_d;
    logic [58:0]      shift_q, shift_d, frame_q, frame_d;
    logic [5:0]       idx_q, idx_d;
    logic             sincro_q, sincro_d, fv_q, fv_d;
    logic [2:0]       err_q, err_d;

    logic rise, fall, gap_hit, width_bad, bit_val, marker_ok, parity_ok;

    // Edges compare the fresh synchronized sample against the previous tick's sample.
    assign rise    = tick_1khz_i & sync2_q & ~samp_q;
    assign fall    = tick_1khz_i & ~sync2_q & samp_q;
    assign gap_hit = tick_1khz_i & ~sync2_q & (lo_cnt_q == GapLast);

    assign width_bad = (hi_cnt_q < Min0) || (hi_cnt_q > Max1);
    assign bit_val   = hi_cnt_q > Max0;
    assign marker_ok = ~shift_q[0] & shift_q[20];
    assign parity_ok = ~(^shift_q[28:21]) & ~(^shift_q[35:29]) & ~(^shift_q[58:36]);

    always_comb begin
        hi_cnt_d = hi_cnt_q;
        lo_cnt_d = lo_cnt_q;
        if (tick_1khz_i) begin
            if (sync2_q) begin
                if (hi_cnt_q != CntMax) hi_cnt_d = hi_cnt_q + 1'b1;
                if (rise) lo_cnt_d = '0;
            end else begin
                if (lo_cnt_q != CntMax) lo_cnt_d = lo_cnt_q + 1'b1;
                if (fall) hi_cnt_d = '0;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        sincro_d = sincro_q;
        frame_d  = frame_q;
        fv_d     = 1'b0;
        err_d    = err_q;
        if (!enable_sincro_i) begin
            state_d  = StIdle;
            sincro_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: state_d = StHunt;
                StHunt: begin
                    sincro_d = 1'b0;
                    if (gap_hit) state_d = StArmed;
                end
                StArmed: begin
                    if (rise) begin
                        state_d  = StReceive;
                        idx_d    = '0;
                        shift_d  = '0;
                        sincro_d = 1'b1;
                    end
                end
                StReceive: begin
                    if (fall) begin
                        if (width_bad) begin
                            err_d    = ErrWidth;
                            state_d  = StHunt;
                            sincro_d = 1'b0;
                        end else if (idx_q < LastBit) begin
                            shift_d[idx_q] = bit_val;
                            idx_d          = idx_q + 1'b1;
                        end
                    end else if (rise && idx_q == LastBit) begin
                        err_d   = ErrCount;
                        state_d = StArmed;
                    end else if (gap_hit) begin
                        state_d = StCheck;
                    end
                end
                StCheck: begin
                    // The gap is trusted on any frame error, so lock is kept.
                    state_d = StArmed;
                    if (idx_q != LastBit) begin
                        err_d = ErrCount;
                    end else if (!marker_ok) begin
                        err_d = ErrMarker;
                    end else if (!parity_ok) begin
                        err_d = ErrParity;
                    end else begin
                        frame_d = shift_q;
                        fv_d    = 1'b1;
                        err_d   = ErrNone;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge qzt_clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            samp_q   <= 1'b0;
            hi_cnt_q <= '0;
            lo_cnt_q <= '0;
            state_q  <= StIdle;
            shift_q  <= '0;
            idx_q    <= '0;
            sincro_q <= 1'b0;
            frame_q  <= '0;
            fv_q     <= 1'b0;
            err_q    <= ErrNone;
        end else begin
            sync1_q  <= sgn_in_i;
            sync2_q  <= sync1_q;
            if (tick_1khz_i) samp_q <= sync2_q;
            hi_cnt_q <= hi_cnt_d;
            lo_cnt_q <= lo_cnt_d;
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            sincro_q <= sincro_d;
            frame_q  <= frame_d;
            fv_q     <= fv_d;
            err_q    <= err_d;
        end
    end

    assign frame_out_o   = frame_q;
    assign frame_valid_o = fv_q;
    assign sincro_o      = sincro_q;
    assign bit_index_o   = idx_q;
    assign last_err_o    = err_q;

endmodule

// File: tb/tb_dcf_frame_sequencer.sv
// Directed bench for dcf_frame_sequencer with time-scaled widths (one tick every two clocks).
module tb_dcf_frame_sequencer;

    localparam int unsigned MIN_0   = 4;
    localparam int unsigned MAX_0   = 14;
    localparam int unsigned MAX_1   = 26;
    localparam int unsigned GAP_MIN = 150;
    localparam int unsigned CNT_W   = 12;

    localparam int W0 = 8;
    localparam int W1 = 18;
    localparam int PERIOD = 30;
    localparam int GAP_TAIL = 160;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        sgn = 1'b0;
    logic        en = 1'b0;
    logic [58:0] frame_out;
    logic        frame_valid;
    logic        sincro;
    logic [5:0]  bit_index;
    logic [2:0]  last_err;

    int n_checks = 0;
    int n_fail = 0;
    int fv_cnt = 0;
    int wov[59];
    logic [58:0] frame_a, frame_b;

    dcf_frame_sequencer #(
        .MIN_0  (MIN_0),
        .MAX_0  (MAX_0),
        .MAX_1  (MAX_1),
        .GAP_MIN(GAP_MIN),
        .CNT_W  (CNT_W)
    ) dut (
        .qzt_clk_i      (clk),
        .reset_i        (rst),
        .tick_1khz_i    (tick),
        .sgn_in_i       (sgn),
        .enable_sincro_i(en),
        .frame_out_o    (frame_out),
        .frame_valid_o  (frame_valid),
        .sincro_o       (sincro),
        .bit_index_o    (bit_index),
        .last_err_o     (last_err)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            tick = ~tick;
        end
    end

    // Counts high cycles, so a stretched pulse shows up as an extra count.
    always @(negedge clk) begin
        if (frame_valid === 1'b1) fv_cnt++;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Two clocks per tick, so the level is seen on exactly n ticks.
    task automatic hold(input logic lvl, input int n);
        sgn = lvl;
        repeat (2 * n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [58:0] f, input int nbits);
        int w;
        for (int i = 0; i < nbits; i++) begin
            w = (wov[i] != 0) ? wov[i] : (f[i] ? W1 : W0);
            hold(1'b1, w);
            hold(1'b0, PERIOD - w);
        end
    endtask

    task automatic gap();
        hold(1'b0, GAP_TAIL);
    endtask

    task automatic clear_wov();
        for (int i = 0; i < 59; i++) wov[i] = 0;
    endtask

    initial begin
        clear_wov();
        // Minute 0x25 (P1=1), hour 0x13 (P2=1), day 0x17, Friday, month 0x05, year 0x24 (P3=0).
        frame_a        = '0;
        frame_a[20]    = 1'b1;
        frame_a[27:21] = 7'h25;
        frame_a[28]    = 1'b1;
        frame_a[34:29] = 6'h13;
        frame_a[35]    = 1'b1;
        frame_a[41:36] = 6'h17;
        frame_a[44:42] = 3'd5;
        frame_a[49:45] = 5'h05;
        frame_a[57:50] = 8'h24;
        frame_a[58]    = 1'b0;
        frame_b        = frame_a;
        frame_b[28]    = ~frame_a[28];

        repeat (3) @(negedge clk);
        check_eq("rst_frame", 64'(frame_out), 64'h0);
        check_eq("rst_valid", 64'(frame_valid), 64'h0);
        check_eq("rst_sincro", 64'(sincro), 64'h0);
        check_eq("rst_index", 64'(bit_index), 64'h0);
        check_eq("rst_err", 64'(last_err), 64'h0);

        rst = 1'b0;
        en  = 1'b1;
        hold(1'b0, 200);
        check_eq("armed_sincro", 64'(sincro), 64'h0);

        send_bits(frame_a, 59);
        check_eq("rx_sincro", 64'(sincro), 64'h1);
        check_eq("rx_index", 64'(bit_index), 64'd59);
        check_eq("pre_commit_valid", 64'(fv_cnt), 64'd0);
        gap();
        check_eq("good_fv_cnt", 64'(fv_cnt), 64'd1);
        check_eq("good_frame", 64'(frame_out), 64'(frame_a));
        check_eq("good_err", 64'(last_err), 64'd0);
        check_eq("good_sincro", 64'(sincro), 64'h1);

        send_bits(frame_b, 59);
        gap();
        check_eq("par_fv_cnt", 64'(fv_cnt), 64'd1);
        check_eq("par_err", 64'(last_err), 64'd3);
        check_eq("par_sincro", 64'(sincro), 64'h1);
        check_eq("par_frame_held", 64'(frame_out), 64'(frame_a));
        send_bits(frame_a, 59);
        gap();
        check_eq("par_recover_fv", 64'(fv_cnt), 64'd2);
        check_eq("par_recover_err", 64'(last_err), 64'd0);

        wov[10] = 3;
        send_bits(frame_a, 59);
        clear_wov();
        gap();
        check_eq("width_err", 64'(last_err), 64'd1);
        check_eq("width_sincro", 64'(sincro), 64'h0);
        check_eq("width_fv_cnt", 64'(fv_cnt), 64'd2);
        send_bits(frame_a, 59);
        gap();
        check_eq("relock_fv_cnt", 64'(fv_cnt), 64'd3);
        check_eq("relock_sincro", 64'(sincro), 64'h1);

        send_bits(frame_a, 58);
        gap();
        check_eq("count_err", 64'(last_err), 64'd2);
        check_eq("count_fv_cnt", 64'(fv_cnt), 64'd3);
        check_eq("count_sincro", 64'(sincro), 64'h1);
        send_bits(frame_a, 59);
        gap();
        check_eq("count_recover_fv", 64'(fv_cnt), 64'd4);
        check_eq("count_recover_err", 64'(last_err), 64'd0);

        // Boundary widths: 4 and 14 must decode as 0, 15 and 26 as 1.
        wov[1]  = 4;
        wov[5]  = 14;
        wov[20] = 15;
        wov[21] = 26;
        send_bits(frame_a, 59);
        clear_wov();
        gap();
        check_eq("bound_fv_cnt", 64'(fv_cnt), 64'd5);
        check_eq("bound_frame", 64'(frame_out), 64'(frame_a));
        check_eq("bound_err", 64'(last_err), 64'd0);
        wov[3] = 27;
        send_bits(frame_a, 59);
        clear_wov();
        gap();
        check_eq("wide_err", 64'(last_err), 64'd1);
        check_eq("wide_sincro", 64'(sincro), 64'h0);
        check_eq("wide_fv_cnt", 64'(fv_cnt), 64'd5);

        send_bits(frame_a, 30);
        check_eq("mid_sincro", 64'(sincro), 64'h1);
        check_eq("mid_index", 64'(bit_index), 64'd30);
        en = 1'b0;
        @(negedge clk);
        check_eq("dis_sincro", 64'(sincro), 64'h0);
        check_eq("dis_frame_held", 64'(frame_out), 64'(frame_a));
        check_eq("dis_index_held", 64'(bit_index), 64'd30);
        hold(1'b1, 10);
        rst = 1'b1;
        #1;
        check_eq("mrst_frame", 64'(frame_out), 64'h0);
        check_eq("mrst_index", 64'(bit_index), 64'h0);
        check_eq("mrst_err", 64'(last_err), 64'h0);
        check_eq("mrst_sincro", 64'(sincro), 64'h0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        hold(1'b0, 20);
        check_eq("mrst_fv_cnt", 64'(fv_cnt), 64'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
